// File: rtl/bram_bridge_pkg.sv
// bram_bridge_pkg: shared FSM state type, default memory timing and beat-mask helper
package bram_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} bridge_state_t;
  localparam int MEM_TIME_DEFAULT = 2;
  // Bit k set when beat k is accessed: every beat on a read, only beats with a non-empty
  // byte-enable slice on a write. bw is the number of bytes per memory beat.
  function automatic logic [3:0] beat_mask(input logic wr, input logic [3:0] we, input int bw);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < 4; k++)
      m[k] = (k * bw < 4) && (!wr || ((we >> (k * bw)) & 4'((1 << bw) - 1)) != 4'd0);
    return m;
  endfunction
endpackage

// File: rtl/bram_bridge_if.sv
// bram_bridge_if: 32-bit MCU request/response bus plus the narrow memory port of the bridge
interface bram_bridge_if #(
  parameter int MEM_DW = 16,
  parameter int ADDR_W = 24
) ();
  logic                mcu_sel;
  logic                mcu_oe;
  logic [3:0]          mcu_we;
  logic [ADDR_W-1:0]   mcu_addr;
  logic [31:0]         mcu_dato;
  logic [31:0]         mcu_dati;
  logic                mcu_ack;
  logic [ADDR_W-1:0]   mem_addr;
  logic [MEM_DW-1:0]   mem_dati;
  logic [MEM_DW-1:0]   mem_dato;
  logic                mem_oe;
  logic [MEM_DW/8-1:0] mem_we;
  modport master (
    output mcu_sel, mcu_oe, mcu_we, mcu_addr, mcu_dato, mem_dato,
    input  mcu_dati, mcu_ack, mem_addr, mem_dati, mem_oe, mem_we
  );
  modport slave (
    input  mcu_sel, mcu_oe, mcu_we, mcu_addr, mcu_dato, mem_dato,
    output mcu_dati, mcu_ack, mem_addr, mem_dati, mem_oe, mem_we
  );
endinterface

// File: rtl/bram_beat_mux.sv
// bram_beat_mux: selects address offset, write data and byte enables for one memory beat
module bram_beat_mux #(
  parameter int MEM_DW = 16,
  parameter int ADDR_W = 24
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         dato,
  input  logic [3:0]          we,
  input  logic [1:0]          beat,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_dati,
  output logic [MEM_DW/8-1:0] mem_we
);
  localparam int BW = MEM_DW / 8;
  always_comb begin
    mem_addr = addr | ADDR_W'(int'(beat) * BW);
    mem_dati = dato[int'(beat) * MEM_DW +: MEM_DW];
    mem_we   = we[int'(beat) * BW +: BW];
  end
endmodule

// File: rtl/bram_bridge.sv
// bram_bridge: splits 32-bit MCU transactions into timed beats on a narrower block-RAM port
module bram_bridge
  import bram_bridge_pkg::*;
#(
  parameter int MEM_DW   = 16,
  parameter int MEM_TIME = MEM_TIME_DEFAULT,
  parameter int ADDR_W   = 24
) (
  input logic          clk,
  input logic          rst_n,
  bram_bridge_if.slave bus
);
  localparam int BW = MEM_DW / 8;
  if (MEM_DW != 8 && MEM_DW != 16 && MEM_DW != 32) begin : g_bad_dw
    $error("bram_bridge: MEM_DW must be 8, 16 or 32");
  end
  if (MEM_TIME < 1 || MEM_TIME > 15) begin : g_bad_time
    $error("bram_bridge: MEM_TIME must be in 1..15");
  end
  bridge_state_t     state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              wr_q, wr_d;
  logic [31:0]       dati_q, dati_d;
  logic [31:0]       dato_q, dato_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        req_mask, run_mask;
  logic [1:0]        first_beat, next_beat;
  logic              next_any, req_wr, strobe_en;
  logic [BW-1:0]     slice_we;
  assign req_wr = |bus.mcu_we;
  // Lowest enabled beat of the incoming request and the next enabled beat after the current one
  always_comb begin
    req_mask   = beat_mask(req_wr, bus.mcu_we, BW);
    run_mask   = beat_mask(wr_q, we_q, BW);
    first_beat = '0;
    next_beat  = '0;
    next_any   = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req_mask[k]) first_beat = 2'(k);
      if (run_mask[k] && k > int'(beat_q)) begin
        next_any  = 1'b1;
        next_beat = 2'(k);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    wr_d    = wr_q;
    dati_d  = dati_q;
    dato_d  = dato_q;
    we_d    = we_q;
    addr_d  = addr_q;
    if (!bus.mcu_sel) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      beat_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_d  = bus.mcu_addr;
          dato_d  = bus.mcu_dato;
          we_d    = bus.mcu_we;
          wr_d    = req_wr;
          cnt_d   = '0;
          beat_d  = first_beat;
          state_d = (req_wr || bus.mcu_oe) ? ACCESS : DONE;
          ack_d   = !(req_wr || bus.mcu_oe);
        end
        ACCESS: begin
          if (cnt_q == 4'(MEM_TIME - 1)) begin
            cnt_d = '0;
            if (!wr_q) dati_d[int'(beat_q) * MEM_DW +: MEM_DW] = bus.mem_dato;
            state_d = next_any ? GAP : DONE;
            beat_d  = next_any ? next_beat : beat_q;
            ack_d   = !next_any;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        GAP:     state_d = ACCESS;
        DONE:    ack_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      wr_q    <= 1'b0;
      dati_q  <= '0;
      dato_q  <= '0;
      we_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      dati_q  <= dati_d;
      dato_q  <= dato_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end
  bram_beat_mux #(.MEM_DW(MEM_DW), .ADDR_W(ADDR_W)) u_mux (
    .addr     (addr_q),
    .dato     (dato_q),
    .we       (we_q),
    .beat     (beat_q),
    .mem_addr (bus.mem_addr),
    .mem_dati (bus.mem_dati),
    .mem_we   (slice_we)
  );
  // Strobes are gated by sel directly so an abort removes them in the same cycle
  assign strobe_en    = state_q == ACCESS && bus.mcu_sel;
  assign bus.mem_oe   = strobe_en && !wr_q;
  assign bus.mem_we   = (strobe_en && wr_q) ? slice_we : '0;
  assign bus.mcu_ack  = ack_q;
  assign bus.mcu_dati = dati_q;
endmodule

// File: doc/bram_bridge.md
BRAM_BRIDGE -- requirements
Module: bram_bridge

Interface
REQ-001 SHALL have parameter MEM_DW, default 16, memory data width; legal values 8, 16, 32.
REQ-002 SHALL have parameter MEM_TIME, default 2, strobe-active cycles per memory beat; legal range 1..15.
REQ-003 SHALL have parameter ADDR_W, default 24, byte-address width.
REQ-004 SHALL have clk  in  1  single clock for all logic, the same net as mcu.clk.
REQ-005 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have mcu_sel  in  1  bram map decode ANDed with MCU chip enable; one transaction per high period.
REQ-007 SHALL have mcu_oe  in  1  MCU read strobe.
REQ-008 SHALL have mcu_we  in  4  MCU byte write enables, bit i for byte i.
REQ-009 SHALL have mcu_addr  in  ADDR_W  word-aligned byte address.
REQ-010 SHALL have mcu_dato  in  32  MCU write data.
REQ-011 SHALL have mcu_dati  out  32  assembled read data.
REQ-012 SHALL have mcu_ack  out  1  transaction complete.
REQ-013 SHALL have mem_addr  out  ADDR_W, mem_dati  out  MEM_DW, mem_oe  out  1, mem_we  out  MEM_DW/8, and mem_dato  in  MEM_DW.

Function
REQ-014 SHALL split each 32-bit transaction into N = 32/MEM_DW beats, k = 0..N-1, in ascending order.
REQ-015 SHALL drive each beat k as follows:
- mem_addr = mcu_addr OR (k*MEM_DW/8).
- mem_dati = mcu_dato[k*MEM_DW +: MEM_DW].
- mem_we = mcu_we[k*MEM_DW/8 +: MEM_DW/8].
REQ-016 SHALL use FSM states IDLE, ACCESS, GAP, DONE, plus a beat index and a 4-bit delay counter.
REQ-017 SHALL classify each transaction from the values sampled at the first edge with mcu_sel=1 in IDLE (edge E0):
- Write if any mcu_we bit is set.
- Otherwise read if mcu_oe=1.
- Otherwise null.
REQ-018 SHALL make reads access all N beats.
REQ-019 SHALL make writes skip any beat whose mcu_we slice is all-zero, with no strobe and zero cycles spent on it.
REQ-020 SHALL, for null transactions and writes with no enabled beat, go IDLE->DONE at E0 so that ack is high after E0.
REQ-021 SHALL assert mem_oe (read) or mem_we (write) combinationally only while state=ACCESS and mcu_sel=1; strobes are 0 in all other states.
REQ-022 SHALL hold ACCESS for exactly MEM_TIME cycles per beat.
REQ-023 SHALL, on a read, capture mem_dato into mcu_dati[k*MEM_DW +: MEM_DW] at the edge that ends the final ACCESS cycle.
REQ-024 SHALL insert one GAP cycle (strobes low, address of the next beat) between consecutive accessed beats, and none after the last beat.
REQ-025 SHALL enter DONE after the last accessed beat and set mcu_ack=1 (registered), holding it until mcu_sel falls.
REQ-026 SHALL give a full read an ack rise at edge E0 + N*MEM_TIME + (N-1); MEM_DW=16, MEM_TIME=2 gives E0+5.
REQ-027 SHALL ignore changes of mcu_oe, mcu_we, mcu_addr and mcu_dato after E0, using values registered at E0.
REQ-028 SHALL handle mcu_sel=0 at any edge: next state IDLE, mcu_ack=0, beat index and counter cleared; strobes drop in the same cycle through the combinational gate.
REQ-029 SHALL retain mcu_dati on abort and between transactions, overwriting only the captured slices.
REQ-030 SHALL require mcu_sel to return low (via IDLE) before a new transaction starts; DONE with sel held high issues no further strobes.

Reset
REQ-031 SHALL, with rst_n=0, asynchronously force:
- state = IDLE.
- mcu_ack = 0.
- mcu_dati = 0.
- beat index and delay counter = 0.
- all latched request fields = 0.
REQ-032 SHALL deassert all memory strobes while rst_n=0.
REQ-033 SHALL start the first transaction after reset release no earlier than the first edge with rst_n=1 and mcu_sel=1.

Structure
REQ-034 SHALL place in the shared package the bridge_state_t enum (IDLE, ACCESS, GAP, DONE) and the default MEM_TIME constant, reused by the existing `MEM_TIME users.
REQ-035 SHALL implement the per-beat address/data/byte-enable slice selection as one combinational sub-module, bram_beat_mux, parameterised by MEM_DW.
REQ-036 SHALL assert, at elaboration, that MEM_DW is in {8,16,32} and MEM_TIME is in 1..15.

Verification
REQ-037 SHALL cover a read with MEM_DW=16, MEM_TIME=2, memory 0x0100=0xBEEF and 0x0102=0xCAFE: ack rises at E0+5 and mcu_dati=0xCAFEBEEF.
REQ-038 SHALL cover a write with MEM_DW=8, mcu_we=4'b1010, dato=0x11223344, addr 0x40: only beats 1 and 3 are strobed (0x41<-0x33, 0x43<-0x11), mem_we high 2+2 cycles, and ack at E0+5.
REQ-039 SHALL cover a write with MEM_DW=32, MEM_TIME=3, we=4'b1111: a single beat with mem_we=4'hF for 3 cycles, no GAP, and ack at E0+3.
REQ-040 SHALL cover a read with MEM_DW=16, MEM_TIME=2 where mcu_sel is dropped at E0+3: strobes are 0 in that cycle, ack never rises, mcu_dati[31:16] is unchanged, and a following read completes normally.
REQ-041 SHALL cover a null access (oe=0, we=0): ack at E0 and zero memory strobes.
REQ-042 SHALL cover rst_n asserted mid-ACCESS: strobes and ack are 0 immediately, and state is IDLE on release.
